// File: rtl/fifo_drain_pkg.sv
// -----------------------------------------------------------------------------
// fifo_drain_pkg
// Shared definitions for the FIFO read-side drain checker.
//   state_t   : checker FSM states (IDLE, RUN, DONE)
//   DEF_SEED  : value of word index 0 in the stimulus ROM pattern
//   DEF_COUNT : words per run; the stimulus ROM uses the same constants so that
//               producer and checker agree on the pattern.
// -----------------------------------------------------------------------------
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_SEED  = 10;
  localparam int DEF_COUNT = 128;

endpackage

// File: rtl/exp_pattern_gen.sv
// -----------------------------------------------------------------------------
// exp_pattern_gen
// Expected-value register for the drain checker: value = index + SEED, wrapping
// modulo 2^WIDTH.
// Ports:
//   rd_clk  in  1      clock
//   reset   in  1      synchronous active-low reset (loads SEED)
//   load    in  1      reload SEED (run entry); wins over step
//   step    in  1      advance to the next expected word (one per pop)
//   exp_val out WIDTH  expected value of the word at the FIFO head
// -----------------------------------------------------------------------------
module exp_pattern_gen
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEED  = DEF_SEED
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] exp_val
);

  always_ff @(posedge rd_clk) begin
    if (!reset || load) begin
      exp_val <= WIDTH'(SEED);
    end else if (step) begin
      // Natural wrap of the WIDTH-bit add gives the modulo 2^WIDTH pattern.
      exp_val <= exp_val + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_drain_checker.sv
// -----------------------------------------------------------------------------
// fifo_drain_checker
// Read-side consumer for the asynchronous FIFO, entirely in the read clock
// domain. Pops words through the first-word-fall-through port and compares each
// against index + SEED (mod 2^WIDTH).
// Optional feature macro: FIFO_DRAIN_CHECKER_TIMEOUT_EN
//   defined   : abort the run (timeout=1, go to DONE) after TIMEOUT consecutive
//               RUN cycles with fifo_empty=1 and hold=0.
//   undefined : no wait counter, timeout tied to 0, RUN waits indefinitely.
// Ports:
//   rd_clk        in  1      sole clock
//   reset         in  1      synchronous active-low reset
//   start         in  1      arm a run from IDLE or DONE (ignored in RUN)
//   hold          in  1      back-pressure; no pop while high
//   fifo_data     in  WIDTH  FIFO head word, valid when fifo_empty=0
//   fifo_empty    in  1      FIFO empty flag
//   rd_en         out 1      pop strobe (combinational)
//   busy          out 1      in RUN
//   done          out 1      in DONE
//   err           out 1      sticky mismatch flag
//   err_count     out CNT_W  mismatch count, saturating
//   first_err_idx out CNT_W  index of first mismatch (valid while err=1)
//   rx_count      out CNT_W  words popped in the current run
//   last_data     out WIDTH  most recently popped word
//   timeout       out 1      run aborted on empty-wait expiry
// -----------------------------------------------------------------------------
module fifo_drain_checker
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SEED    = DEF_SEED,
  parameter int COUNT   = DEF_COUNT,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             rd_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [CNT_W-1:0] rx_count,
  output logic [WIDTH-1:0] last_data,
  output logic             timeout
);

  state_t           state;
  logic [WIDTH-1:0] exp_val;
  logic             pop;
  logic             run_entry;
  logic             mismatch;
  logic             last_pop;
  logic             wait_expired;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Gated by reset so a reset landing mid-run does not pop the FIFO that edge.
  assign rd_en     = reset & busy & ~fifo_empty & ~hold;
  assign pop       = rd_en;
  assign run_entry = reset & start & (state != RUN);
  assign mismatch  = (fifo_data != exp_val);
  assign last_pop  = pop & (rx_count == CNT_W'(COUNT - 1));

  exp_pattern_gen #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_exp (
    .rd_clk  (rd_clk),
    .reset   (reset),
    .load    (run_entry),
    .step    (pop),
    .exp_val (exp_val)
  );

  // Pop / compare stage: head word is checked on the same edge it is popped.
  always_ff @(posedge rd_clk) begin
    if (!reset) begin
      state         <= IDLE;
      rx_count      <= '0;
      err           <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      last_data     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            rx_count      <= '0;
            err           <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
          end
        end
        RUN: begin
          if (pop) begin
            last_data <= fifo_data;
            rx_count  <= rx_count + 1'b1;
            if (mismatch) begin
              err       <= 1'b1;
              err_count <= sat_inc(err_count);
              if (!err) first_err_idx <= rx_count;
            end
            if (last_pop) state <= DONE;
          end else if (wait_expired) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_DRAIN_CHECKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  // Fires on the TIMEOUT-th consecutive qualifying empty cycle.
  assign wait_expired = busy & fifo_empty & ~hold & (wait_cnt == TW'(TIMEOUT - 1));

  // Empty-wait stage: hold cycles neither count nor clear the wait.
  always_ff @(posedge rd_clk) begin
    if (!reset || run_entry) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (busy) begin
      if (pop) begin
        wait_cnt <= '0;
      end else if (wait_expired) begin
        timeout  <= 1'b1;
      end else if (fifo_empty && !hold) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  // TIMEOUT only matters when the wait counter is built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT > 0);
  assign wait_expired       = 1'b0;
  assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_drain_checker.sv
module tb_fifo_drain_checker;

  localparam int W       = 8;
  localparam int SEED    = 10;
  localparam int CNT_W   = 8;
  localparam int TMO     = 4;
  localparam int NDUT    = 2;
  localparam int COUNT_A = 8;
  localparam int COUNT_B = 250;

  logic rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  logic [NDUT-1:0]            reset_v;
  logic [NDUT-1:0]            start_v;
  logic [NDUT-1:0]            hold_v;
  logic [NDUT-1:0]            fifo_empty_v;
  logic [NDUT-1:0][W-1:0]     fifo_data_v;
  logic [NDUT-1:0]            rd_en_v, busy_v, done_v, err_v, timeout_v;
  logic [NDUT-1:0][CNT_W-1:0] err_count_v, first_err_idx_v, rx_count_v;
  logic [NDUT-1:0][W-1:0]     last_data_v;

  fifo_drain_checker #(
    .WIDTH(W), .SEED(SEED), .COUNT(COUNT_A), .CNT_W(CNT_W), .TIMEOUT(TMO)
  ) u_dut_a (
    .rd_clk(rd_clk), .reset(reset_v[0]), .start(start_v[0]), .hold(hold_v[0]),
    .fifo_data(fifo_data_v[0]), .fifo_empty(fifo_empty_v[0]), .rd_en(rd_en_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .err_count(err_count_v[0]),
    .first_err_idx(first_err_idx_v[0]), .rx_count(rx_count_v[0]),
    .last_data(last_data_v[0]), .timeout(timeout_v[0])
  );

  fifo_drain_checker #(
    .WIDTH(W), .SEED(SEED), .COUNT(COUNT_B), .CNT_W(CNT_W), .TIMEOUT(255)
  ) u_dut_b (
    .rd_clk(rd_clk), .reset(reset_v[1]), .start(start_v[1]), .hold(hold_v[1]),
    .fifo_data(fifo_data_v[1]), .fifo_empty(fifo_empty_v[1]), .rd_en(rd_en_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .err_count(err_count_v[1]),
    .first_err_idx(first_err_idx_v[1]), .rx_count(rx_count_v[1]),
    .last_data(last_data_v[1]), .timeout(timeout_v[1])
  );

  int total = 0;
  int bad   = 0;

  // Reference model: run flags plus per-run tallies; expected word by index.
  bit         m_run  [NDUT];
  bit         m_fin  [NDUT];
  bit         m_tmo  [NDUT];
  int         m_rx   [NDUT];
  int         m_errs [NDUT];
  int         m_first[NDUT];
  int         m_wait [NDUT];
  logic [7:0] m_last [NDUT];

  // Words currently sitting in the FIFO feeding the active DUT.
  logic [7:0] fq[$];

  typedef struct {
    bit hold;
    bit exp_rd;
    int exp_rx;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [7:0] exp_word(input int i);
    return 8'((SEED + i) % 256);
  endfunction

  function automatic int count_of(input int d);
    return (d == 0) ? COUNT_A : COUNT_B;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int d);
    m_run[d] = 0; m_fin[d] = 0; m_tmo[d] = 0; m_rx[d] = 0;
    m_errs[d] = 0; m_first[d] = 0; m_wait[d] = 0; m_last[d] = '0;
  endtask

  task automatic fill(input int n, input int bad_idx);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back((i == bad_idx) ? 8'h00 : exp_word(i));
  endtask

  task automatic check_outputs(input int d);
    chk("busy", busy_v[d], m_run[d]);
    chk("done", done_v[d], m_fin[d]);
    chk("err", err_v[d], m_errs[d] > 0);
    chk("err_count", err_count_v[d], (m_errs[d] > 255) ? 255 : m_errs[d]);
    chk("first_err_idx", first_err_idx_v[d], m_first[d]);
    chk("rx_count", rx_count_v[d], m_rx[d]);
    chk("last_data", last_data_v[d], m_last[d]);
    chk("timeout", timeout_v[d], m_tmo[d]);
  endtask

  // One clock cycle on DUT d, entered and left on a falling edge.
  task automatic step(input int d, input bit st, input bit hd, input bit gap,
                      input bit rst_n, output bit rd_seen);
    bit empty;
    bit pop;
    reset_v[d]      = rst_n;
    start_v[d]      = st;
    hold_v[d]       = hd;
    empty           = gap || (fq.size() == 0);
    fifo_empty_v[d] = empty;
    fifo_data_v[d]  = empty ? W'($urandom) : fq[0];
    #1;
    pop     = rst_n && m_run[d] && !empty && !hd;
    rd_seen = rd_en_v[d];
    chk("rd_en", rd_en_v[d], pop);
    @(posedge rd_clk);
    if (!rst_n) begin
      model_reset(d);
    end else if (m_run[d]) begin
      if (pop) begin
        if (fq[0] != exp_word(m_rx[d])) begin
          if (m_errs[d] == 0) m_first[d] = m_rx[d];
          m_errs[d]++;
        end
        m_last[d] = fq[0];
        m_rx[d]++;
        m_wait[d] = 0;
        void'(fq.pop_front());
        if (m_rx[d] == count_of(d)) begin m_run[d] = 0; m_fin[d] = 1; end
      end else if (empty && !hd) begin
`ifdef FIFO_DRAIN_CHECKER_TIMEOUT_EN
        m_wait[d]++;
        if (m_wait[d] == TMO) begin m_tmo[d] = 1; m_run[d] = 0; m_fin[d] = 1; end
`endif
      end
    end else if (st) begin
      m_run[d] = 1; m_fin[d] = 0; m_tmo[d] = 0; m_rx[d] = 0;
      m_errs[d] = 0; m_first[d] = 0; m_wait[d] = 0;
    end
    @(negedge rd_clk);
    check_outputs(d);
    reset_v[d] = 1'b1; start_v[d] = 1'b0; hold_v[d] = 1'b0; fifo_empty_v[d] = 1'b1;
  endtask

  task automatic tick(input int d);
    bit r;
    step(d, 0, 0, 0, 1, r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=still running want=finished");
    $fatal(1);
  end

  initial begin
    bit r;
    int ones;

    // hold during cycles 2-4 of an 8-word run; last row is the first DONE cycle
    tbl[0]  = '{0, 1, 1};  tbl[1]  = '{0, 1, 2};  tbl[2]  = '{1, 0, 2};
    tbl[3]  = '{1, 0, 2};  tbl[4]  = '{1, 0, 2};  tbl[5]  = '{0, 1, 3};
    tbl[6]  = '{0, 1, 4};  tbl[7]  = '{0, 1, 5};  tbl[8]  = '{0, 1, 6};
    tbl[9]  = '{0, 1, 7};  tbl[10] = '{0, 1, 8};  tbl[11] = '{0, 0, 8};

    reset_v = '0; start_v = '0; hold_v = '0; fifo_empty_v = '1; fifo_data_v = '0;
    model_reset(0); model_reset(1);
    @(negedge rd_clk);

    // Reset state of both instances
    step(0, 0, 0, 0, 0, r);
    step(1, 0, 0, 0, 0, r);

    // Clean 8-word run, then extra words must not be popped in DONE
    fill(8, -1);
    step(0, 1, 0, 0, 1, r);
    ones = 0;
    for (int i = 0; i < 8; i++) begin step(0, 0, 0, 0, 1, r); ones += int'(r); end
    chk("basic_rd_en_cycles", ones, 8);
    chk("basic_done", done_v[0], 1);
    chk("basic_rx", rx_count_v[0], 8);
    chk("basic_err", err_v[0], 0);
    chk("basic_last", last_data_v[0], 17);
    fq.push_back(8'h55); fq.push_back(8'h56);
    for (int i = 0; i < 3; i++) begin step(0, 0, 0, 0, 1, r); chk("done_no_pop", r, 0); end

    // Word 3 corrupted to 0x00
    fill(8, 3);
    step(0, 1, 0, 0, 1, r);
    for (int i = 0; i < 8; i++) tick(0);
    chk("corrupt_err", err_v[0], 1);
    chk("corrupt_err_count", err_count_v[0], 1);
    chk("corrupt_first_idx", first_err_idx_v[0], 3);
    chk("corrupt_rx", rx_count_v[0], 8);
    chk("corrupt_done", done_v[0], 1);

    // Hold table
    fill(9, -1);
    step(0, 1, 0, 0, 1, r);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, tbl[i].hold, 0, 1, r);
      chk("tbl_rd_en", r, tbl[i].exp_rd);
      chk("tbl_rx", rx_count_v[0], tbl[i].exp_rx);
    end
    chk("hold_err", err_v[0], 0);
    chk("hold_last", last_data_v[0], 17);

    // Reset at rx_count=5 with words still queued
    fill(8, -1);
    step(0, 1, 0, 0, 1, r);
    for (int i = 0; i < 5; i++) tick(0);
    chk("midrst_rx_before", rx_count_v[0], 5);
    step(0, 0, 0, 0, 0, r);
    chk("midrst_no_pop", r, 0);
    chk("midrst_busy", busy_v[0], 0);
    chk("midrst_rx", rx_count_v[0], 0);
    step(0, 0, 0, 0, 1, r);
    chk("midrst_idle_rd_en", r, 0);

    // 250-word run across the 255 -> 0 wrap, random holds and gaps
    fill(COUNT_B, -1);
    step(1, 1, 0, 0, 1, r);
    for (int c = 0; c < 2000 && m_run[1]; c++)
      step(1, 0, ($urandom_range(3) == 0), ($urandom_range(4) == 0), 1, r);
    chk("wrap_done", done_v[1], 1);
    chk("wrap_err", err_v[1], 0);
    chk("wrap_rx", rx_count_v[1], COUNT_B);
    chk("wrap_last", last_data_v[1], 3);

    // Randomized runs against the model
    for (int run = 0; run < 12; run++) begin
      fq.delete();
      for (int i = 0; i < 8; i++)
        fq.push_back(($urandom_range(3) == 0) ? 8'($urandom) : exp_word(i));
      step(0, 1, 0, 0, 1, r);
      for (int c = 0; c < 200 && m_run[0]; c++)
        step(0, ($urandom_range(5) == 0), ($urandom_range(3) == 0),
             ($urandom_range(5) == 0), ($urandom_range(60) != 0), r);
      for (int c = 0; c < 2; c++) tick(0);
    end

    // Empty-wait behaviour
    fq.delete();
    step(0, 1, 0, 0, 1, r);
`ifdef FIFO_DRAIN_CHECKER_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) tick(0);
    chk("tmo_not_yet", done_v[0], 0);
    tick(0);
    chk("tmo_flag", timeout_v[0], 1);
    chk("tmo_done", done_v[0], 1);
`else
    for (int i = 0; i < 10; i++) tick(0);
    chk("wait_busy", busy_v[0], 1);
    chk("wait_no_timeout", timeout_v[0], 0);
    step(0, 0, 0, 0, 0, r);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_drain_checker.md
Name: fifo_drain_checker

Overview:
- Read-side consumer for the asynchronous FIFO; runs entirely in the read clock domain.
- Pops words through the FIFO's first-word-fall-through read port and compares each against the expected ROM stimulus pattern (value = index + SEED, mod 2^WIDTH).
- Reports received count, mismatch count, first failing index and completion status to the bench or top level.

Parameters:
- WIDTH, 8, data word width; must match the FIFO.
- SEED, 10, expected value of word index 0.
- COUNT, 128, words consumed per run; legal range 1 to 2^CNT_W-1.
- CNT_W, 8, width of the index and error counters.
- TIMEOUT, 255, maximum empty-wait cycles in RUN; used only with the optional feature.

Ports:
- rd_clk, in, 1, sole clock.
- reset, in, 1, synchronous active-low reset; sampled only on the rising edge of rd_clk.
- start, in, 1, arms a run from IDLE or DONE.
- hold, in, 1, consumer back-pressure; while high, no pop occurs.
- fifo_data, in, WIDTH, FIFO read data; valid whenever fifo_empty is 0.
- fifo_empty, in, 1, FIFO empty flag.
- rd_en, out, 1, pop strobe; the FIFO advances on each rd_clk edge where rd_en is 1.
- busy, out, 1, high in RUN.
- done, out, 1, high in DONE.
- err, out, 1, sticky; set on any mismatch.
- err_count, out, CNT_W, mismatch count; saturates at all-ones.
- first_err_idx, out, CNT_W, index of the first mismatch; valid while err is 1.
- rx_count, out, CNT_W, words popped in the current run.
- last_data, out, WIDTH, most recently popped word.
- timeout, out, 1, run aborted on empty-wait expiry.

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE.
  - All counters, flags and last_data are cleared to 0; rd_en is 0.
  - The expected register loads SEED.
  - Reset mid-run aborts the run immediately; the FIFO is not popped in that cycle.
- States and transitions:
  - IDLE -> RUN when start=1.
  - RUN -> DONE on the pop that makes rx_count equal COUNT.
  - DONE -> RUN when start=1.
  - start is ignored while in RUN.
- Run entry: entering RUN from IDLE or DONE clears rx_count, err, err_count, first_err_idx and timeout, and reloads expected to SEED.
- rd_en is combinational: (state==RUN) & ~fifo_empty & ~hold. The pop and the compare happen on the same edge, so there is zero-cycle latency from fifo_empty falling to rd_en rising.
- On each pop:
  - last_data <= fifo_data.
  - rx_count increments.
  - expected <= expected+1; wraps modulo 2^WIDTH (e.g. 255 -> 0).
  - If fifo_data != expected: err is set, err_count increments with saturation, and first_err_idx <= rx_count only when err was previously 0.
- fifo_empty=1 or hold=1: no pop, and all state holds.
- If hold and fifo_empty change in the same cycle, hold takes priority: no pop.
- Outputs are registered except rd_en, busy and done, which are decoded from state.
- The final pop sets done in the next cycle; rd_en must be 0 throughout DONE even if the FIFO is non-empty.

Optional Feature:
- Macro: FIFO_DRAIN_CHECKER_TIMEOUT_EN.
- When defined:
  - A wait counter counts consecutive RUN cycles with fifo_empty=1 and hold=0.
  - The counter clears on any pop or on run entry.
  - When it reaches TIMEOUT, the block sets timeout=1 and goes to DONE.
- When undefined:
  - The counter is not built.
  - timeout is tied to 0.
  - RUN waits indefinitely.

Decomposition:
- Shared package fifo_drain_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default SEED and COUNT constants, shared with the stimulus ROM so that both ends agree.
- One sub-module, exp_pattern_gen: holds the expected-value register, with load (SEED) and step (increment) controls.

Test Plan:
- Reset, then start, with the FIFO pre-filled with 10..17 and COUNT=8 -> rd_en high for 8 consecutive cycles; done=1, rx_count=8, err=0, last_data=17.
- Word index 3 corrupted to 0x00 (expected 13) -> err=1, err_count=1, first_err_idx=3; the run still completes with rx_count=8.
- hold=1 for cycles 2-4 with fifo_empty=0 -> rd_en=0 during the hold, no count change, and the sequence resumes intact.
- COUNT=250, SEED=10 -> expected wraps 255->0 at index 245 with no false error.
- reset=0 asserted mid-run at rx_count=5 -> next cycle: IDLE, rx_count=0, rd_en=0. With the macro defined, TIMEOUT=4 and an empty FIFO -> timeout=1 and done=1 after 4 empty cycles.
